// File: rtl/conv3x3_engine.sv
`default_nettype none
// ============================================================================
//  Module   : conv3x3_engine
//  Brief    : 3x3 convolution layer engine with stride 1 and zero padding of 1.
//             It issues one multiply-accumulate per cycle from synchronous RAM
//             read ports. ReLU is optional and the output saturates to DATA_W.
//  Revision : 1.0 - initial release
// ============================================================================
module conv3x3_engine #(
    parameter int IN_CH  = 16,
    parameter int OUT_CH = 32,
    parameter int H      = 14,
    parameter int W      = 14,
    parameter int DATA_W = 32,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 48,
    localparam int FA = (IN_CH * H * W > 1)       ? $clog2(IN_CH * H * W)       : 1,
    localparam int WA = (OUT_CH * IN_CH * 9 > 1)  ? $clog2(OUT_CH * IN_CH * 9)  : 1,
    localparam int BA = (OUT_CH > 1)              ? $clog2(OUT_CH)              : 1,
    localparam int OA = (OUT_CH * H * W > 1)      ? $clog2(OUT_CH * H * W)      : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     relu_en,
    output logic                     busy,
    output logic                     done,
    output logic                     fm_rd_en,
    output logic [FA-1:0]            fm_rd_addr,
    input  logic signed [DATA_W-1:0] fm_rd_data,
    output logic [WA-1:0]            wt_rd_addr,
    input  logic signed [WGT_W-1:0]  wt_rd_data,
    output logic [BA-1:0]            b_rd_addr,
    input  logic signed [DATA_W-1:0] b_rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OA-1:0]            out_addr,
    output logic signed [DATA_W-1:0] out_data
);

    localparam int CW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam int YW = (H > 1)     ? $clog2(H)     : 1;
    localparam int XW = (W > 1)     ? $clog2(W)     : 1;

    // Saturation bounds for DATA_W, expressed at accumulator width
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_BIAS = 3'd1,
        S_MAC       = 3'd2,
        S_DRAIN     = 3'd3,
        S_EMIT      = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [BA-1:0]            f_q;
    logic [YW-1:0]            y_q;
    logic [XW-1:0]            x_q;
    logic [CW-1:0]            c_q;
    logic [1:0]               ky_q;
    logic [1:0]               kx_q;
    logic                     relu_q;
    logic                     tap_ok_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [OA-1:0]            out_addr_q;
    logic signed [DATA_W-1:0] out_data_q;

    logic                     w_inb;
    logic                     w_first_tap;
    logic                     w_last_tap;
    logic                     w_last_pix;
    logic signed [ACC_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]  w_term;
    logic signed [ACC_W-1:0]  w_acc_sum;
    logic signed [ACC_W-1:0]  w_relu;
    logic signed [DATA_W-1:0] w_sat;

    // Padding taps: the input coordinate falls off one edge of the map
    assign w_inb = !((y_q == '0 && ky_q == 2'd0) || (y_q == YW'(H - 1) && ky_q == 2'd2) ||
                     (x_q == '0 && kx_q == 2'd0) || (x_q == XW'(W - 1) && kx_q == 2'd2));

    assign w_first_tap = (c_q == '0) && (ky_q == 2'd0) && (kx_q == 2'd0);
    assign w_last_tap  = (c_q == CW'(IN_CH - 1)) && (ky_q == 2'd2) && (kx_q == 2'd2);
    assign w_last_pix  = (f_q == BA'(OUT_CH - 1)) && (y_q == YW'(H - 1)) && (x_q == XW'(W - 1));

    // Product of the tap issued last cycle; padding taps contribute zero
    assign w_prod    = ACC_W'(fm_rd_data) * ACC_W'(wt_rd_data);
    assign w_term    = tap_ok_q ? w_prod : '0;
    assign w_acc_sum = acc_q + w_term;
    assign w_relu    = (relu_q && w_acc_sum[ACC_W-1]) ? '0 : w_acc_sum;
    assign w_sat     = (w_relu > SAT_MAX) ? DATA_W'(SAT_MAX) :
                       (w_relu < SAT_MIN) ? DATA_W'(SAT_MIN) : DATA_W'(w_relu);

    assign b_rd_addr = f_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        done       = 1'b0;
        out_valid  = 1'b0;
        fm_rd_en   = 1'b0;
        fm_rd_addr = '0;
        wt_rd_addr = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD_BIAS;
            end
            S_LOAD_BIAS: begin
                busy    = 1'b1;
                state_d = S_MAC;
            end
            S_MAC: begin
                busy       = 1'b1;
                fm_rd_en   = w_inb;
                fm_rd_addr = w_inb ? FA'(32'(c_q) * 32'(H * W) + (32'(y_q) + 32'(ky_q)) * 32'(W)
                                        + 32'(x_q) + 32'(kx_q) - 32'(W) - 32'd1) : '0;
                wt_rd_addr = WA'(32'(f_q) * 32'(IN_CH * 9) + 32'(c_q) * 32'd9
                                 + 32'(ky_q) * 32'd3 + 32'(kx_q));
                if (w_last_tap) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy    = 1'b1;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = w_last_pix ? S_DONE : S_LOAD_BIAS;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counters, accumulator and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            f_q        <= '0;
            y_q        <= '0;
            x_q        <= '0;
            c_q        <= '0;
            ky_q       <= '0;
            kx_q       <= '0;
            relu_q     <= 1'b0;
            tap_ok_q   <= 1'b0;
            acc_q      <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            tap_ok_q <= (state_q == S_MAC) && w_inb;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        f_q    <= '0;
                        y_q    <= '0;
                        x_q    <= '0;
                        relu_q <= relu_en;
                    end
                end
                S_LOAD_BIAS: begin
                    c_q  <= '0;
                    ky_q <= '0;
                    kx_q <= '0;
                end
                S_MAC: begin
                    acc_q <= w_first_tap ? ACC_W'(b_rd_data) : w_acc_sum;
                    if (!w_last_tap) begin
                        if (kx_q == 2'd2) begin
                            kx_q <= '0;
                            if (ky_q == 2'd2) begin
                                ky_q <= '0;
                                c_q  <= c_q + CW'(1);
                            end else begin
                                ky_q <= ky_q + 2'd1;
                            end
                        end else begin
                            kx_q <= kx_q + 2'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    acc_q      <= w_acc_sum;
                    out_data_q <= w_sat;
                    out_addr_q <= OA'(32'(f_q) * 32'(H * W) + 32'(y_q) * 32'(W) + 32'(x_q));
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (x_q == XW'(W - 1)) begin
                            x_q <= '0;
                            if (y_q == YW'(H - 1)) begin
                                y_q <= '0;
                                f_q <= f_q + BA'(1);
                            end else begin
                                y_q <= y_q + YW'(1);
                            end
                        end else begin
                            x_q <= x_q + XW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv3x3_engine
//  Brief    : Scoreboard bench for conv3x3_engine on a 1-in, 2-out, 3x3 shape.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv3x3_engine;

    localparam int IN_CH  = 1;
    localparam int OUT_CH = 2;
    localparam int H      = 3;
    localparam int W      = 3;
    localparam int DONE_CYC = OUT_CH * H * W * (IN_CH * 9 + 3) + 1;  // 217

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               relu_en = 1'b0;
    logic               busy, done, fm_rd_en, out_valid;
    logic               out_ready = 1'b1;
    logic [3:0]         fm_rd_addr;
    logic [4:0]         wt_rd_addr;
    logic [0:0]         b_rd_addr;
    logic [4:0]         out_addr;
    logic signed [31:0] fm_rd_data = '0;
    logic signed [7:0]  wt_rd_data = '0;
    logic signed [31:0] b_rd_data = '0;
    logic signed [31:0] out_data;

    logic signed [31:0] fm [9];
    logic signed [7:0]  wt [18];
    logic signed [31:0] bm [2];

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0, n_fail = 0;   // direct checks
    int m_tests = 0, m_fail = 0;   // scoreboard monitor checks

    int ones_res[9] = '{4, 6, 4, 6, 9, 6, 4, 6, 4};
    int left_res[9] = '{0, -2, -4, 0, -8, -10, 0, -14, -16};

    conv3x3_engine #(
        .IN_CH(IN_CH), .OUT_CH(OUT_CH), .H(H), .W(W),
        .DATA_W(32), .WGT_W(8), .ACC_W(48)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
        .busy(busy), .done(done),
        .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr), .fm_rd_data(fm_rd_data),
        .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data),
        .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data)
    );

    always #5 clk = ~clk;

    // Synchronous RAM models; feature data only updates on a strobe
    always @(posedge clk) begin
        if (fm_rd_en) fm_rd_data <= (fm_rd_addr < 4'd9) ? fm[fm_rd_addr] : 32'sd0;
        wt_rd_data <= (wt_rd_addr < 5'd18) ? wt[wt_rd_addr] : 8'sd0;
        b_rd_data  <= bm[b_rd_addr];
    end

    // Monitor: every accepted result is popped and compared
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            m_tests++;
            if (sb.size() == 0) begin
                m_fail++;
                $display("FAIL unexpected_output: addr=%0d data=%0d, none expected", out_addr, out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_addr !== e.a || out_data !== e.d) begin
                    m_fail++;
                    $display("FAIL output: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                             out_addr, out_data, e.a, $signed(e.d));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic push(input int a, input logic [31:0] d);
        exp_t e;
        e.a = 5'(a);
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic load(input int kind);
        for (int i = 0; i < 18; i++) wt[i] = 8'sd0;
        for (int i = 0; i < 9; i++) begin
            case (kind)
                0: begin fm[i] = 32'sd1;          wt[i] = 8'sd1;   end
                1: begin fm[i] = 32'sd1073741824; wt[i] = 8'sd127; wt[9+i] = -8'sd128; end
                default: fm[i] = 32'(i + 1);
            endcase
        end
        case (kind)
            0:       begin bm[0] = 32'sd0; bm[1] = -32'sd100; end
            1:       begin bm[0] = 32'sd0; bm[1] = 32'sd0;    end
            default: begin bm[0] = 32'sd5; bm[1] = 32'sd0; wt[4] = 8'sd1; wt[12] = -8'sd2; end
        endcase
    endtask

    // One run; cycle 0 is the cycle start is accepted in IDLE
    task automatic run(input bit relu, input int stall_at, input int reset_at,
                       input int mstart_at, input int exp_done);
        int cyc;
        logic busy_prev;
        busy_prev = 1'b0;
        @(negedge clk);
        start = 1'b1;
        relu_en = relu;
        @(posedge clk); #1;
        start = 1'b0;
        relu_en = ~relu;
        cyc = 1;
        chk("busy_cycle1", busy, 1);
        while (cyc < 2000 && !done) begin
            if (stall_at != 0) begin
                if (cyc == stall_at) out_ready = 1'b0;
                if (cyc >= stall_at + 6 && cyc <= stall_at + 11) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_addr", out_addr, 2);
                    chk("stall_data", out_data, 4);
                    chk("stall_fm_rd_en", fm_rd_en, 0);
                end
                if (cyc == stall_at + 11) out_ready = 1'b1;
            end
            if (mstart_at != 0) begin
                if (cyc == mstart_at) start = 1'b1;
                if (cyc == mstart_at + 1) start = 1'b0;
            end
            if (reset_at != 0 && cyc == reset_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_fm_rd_en", fm_rd_en, 0);
                chk("rst_out_addr", out_addr, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_fm_rd_addr", fm_rd_addr, 0);
                chk("rst_wt_rd_addr", wt_rd_addr, 0);
                chk("rst_b_rd_addr", b_rd_addr, 0);
                return;
            end
            busy_prev = busy;
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_cycle", cyc, exp_done);
        chk("busy_before_done", busy_prev, 1);
        chk("busy_at_done", busy, 0);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_fm_rd_en", fm_rd_en, 0);
        chk("reset_out_addr", out_addr, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_wt_rd_addr", wt_rd_addr, 0);
        reset = 1'b0;

        // All-ones map and filter, negative bias on filter 1; stray start mid-run
        load(0);
        for (int i = 0; i < 9; i++) push(i, 32'(ones_res[i]));
        for (int i = 0; i < 9; i++) push(9 + i, -32'sd100);
        run(1'b0, 0, 0, 50, DONE_CYC);

        // ReLU clamps the negative-bias filter to zero
        for (int i = 0; i < 9; i++) push(i, 32'(ones_res[i]));
        for (int i = 0; i < 9; i++) push(9 + i, 32'sd0);
        run(1'b1, 0, 0, 0, DONE_CYC);

        // Five-cycle stall on pixel 2 delays done by five
        for (int i = 0; i < 9; i++) push(i, 32'(ones_res[i]));
        for (int i = 0; i < 9; i++) push(9 + i, -32'sd100);
        run(1'b0, 30, 0, 0, DONE_CYC + 5);

        // Positive and negative saturation
        load(1);
        for (int i = 0; i < 9; i++) push(i, 32'h7FFF_FFFF);
        for (int i = 0; i < 9; i++) push(9 + i, 32'h8000_0000);
        run(1'b0, 0, 0, 0, DONE_CYC);

        // Identity filter plus bias and a left-neighbour filter; reset during pixel 10
        load(2);
        for (int i = 0; i < 9; i++) push(i, 32'(i + 6));
        push(9, 32'(left_res[0]));
        run(1'b0, 0, 125, 0, 0);
        chk("partial_run_outputs", sb.size(), 0);

        // A fresh start after the reset reproduces the whole set
        for (int i = 0; i < 9; i++) push(i, 32'(i + 6));
        for (int i = 0; i < 9; i++) push(9 + i, 32'(left_res[i]));
        run(1'b0, 0, 0, 0, DONE_CYC);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests + m_tests, n_fail + m_fail);
        $finish;
    end

endmodule
`default_nettype wire
